// File: rtl/c64_bus_pkg.sv
// Shared definitions for the c64 CPU-bus memory responder: bus widths,
// open-bus default and the boot/run state encoding.
package c64_bus_pkg;

    localparam int CPU_AW = 16;
    localparam int CPU_DW = 8;

    localparam logic [CPU_DW-1:0] OPEN_BUS_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/c64_bus_memory_if.sv
// CPU bus plus boot-loader byte stream, seen from the CPU/loader side (master)
// and from the memory responder (slave).
interface c64_bus_memory_if;
    import c64_bus_pkg::*;

    logic [CPU_AW-1:0] cpu_ab;
    logic              cpu_we;
    logic [CPU_DW-1:0] cpu_do;
    logic [CPU_DW-1:0] cpu_di;
    logic              cpu_reset;

    logic              ld_valid;
    logic [CPU_DW-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_overflow;

    modport master (
        output cpu_ab, cpu_we, cpu_do, ld_valid, ld_data, ld_last,
        input  cpu_di, cpu_reset, ld_ready, ld_overflow
    );

    modport slave (
        input  cpu_ab, cpu_we, cpu_do, ld_valid, ld_data, ld_last,
        output cpu_di, cpu_reset, ld_ready, ld_overflow
    );

endinterface

// File: rtl/c64_bus_ram.sv
// Single-port byte array: combinational read at the CPU address, synchronous
// write from either the loader or the CPU depending on the boot state.
module c64_bus_ram
    import c64_bus_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  state_t            state,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [CPU_DW-1:0] ld_data,
    input  logic              cpu_we,
    input  logic [MEM_AW-1:0] cpu_addr,
    input  logic [CPU_DW-1:0] cpu_data,
    output logic [CPU_DW-1:0] rd_data
);

    logic [CPU_DW-1:0] mem [2**MEM_AW];

    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [CPU_DW-1:0] wr_data;

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ld_addr;
        wr_data = ld_data;
        case (state)
            S_LOAD: wr_en = ld_we;
            S_RUN: begin
                wr_en   = cpu_we;
                wr_addr = cpu_addr;
                wr_data = cpu_data;
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset: contents survive a reset so a partial
    // image stays visible, and a reset port would block RAM inference.
    // Non-blocking assignment keeps the write ordered against same-edge readers.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[cpu_addr];

endmodule

// File: rtl/c64_bus_memory.sv
// CPU-bus memory responder that boots the CPU: loads a program image from a
// byte stream with the CPU held in reset, then hands the memory to the CPU.
module c64_bus_memory
    import c64_bus_pkg::*;
#(
    parameter int                MEM_AW   = 10,
    parameter int                HOLD_CYC = 4,
    parameter logic [CPU_DW-1:0] OPEN_BUS = OPEN_BUS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    c64_bus_memory_if.slave   bus
);

    localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t            state;
    logic [MEM_AW:0]   ptr;
    logic [HCW-1:0]    hold_cnt;
    logic              ld_ready_q;
    logic              cpu_reset_q;
    logic              overflow_q;

    logic              ld_xfer;
    logic              ptr_full;
    logic [CPU_AW-1:0] ab_high;
    logic              cpu_mapped;
    logic [CPU_DW-1:0] rd_data;
    logic [CPU_DW-1:0] cpu_di;

    assign ld_xfer    = bus.ld_valid && ld_ready_q;
    assign ptr_full   = ptr[MEM_AW];
    assign ab_high    = bus.cpu_ab >> MEM_AW;
    assign cpu_mapped = (ab_high == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_INIT;
            ptr         <= '0;
            hold_cnt    <= '0;
            ld_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    ptr        <= '0;
                    overflow_q <= 1'b0;
                    ld_ready_q <= 1'b1;
                    state      <= S_LOAD;
                end
                S_LOAD: begin
                    if (ld_xfer) begin
                        // Past the end the pointer saturates; bytes are still consumed.
                        if (ptr_full) overflow_q <= 1'b1;
                        else          ptr        <= ptr + 1'b1;
                        if (bus.ld_last) begin
                            ld_ready_q <= 1'b0;
                            hold_cnt   <= HCW'(HOLD_CYC - 1);
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        cpu_reset_q <= 1'b0;
                        state       <= S_RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    c64_bus_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk      (clk),
        .state    (state),
        .ld_we    (ld_xfer && !ptr_full),
        .ld_addr  (ptr[MEM_AW-1:0]),
        .ld_data  (bus.ld_data),
        .cpu_we   (bus.cpu_we && cpu_mapped),
        .cpu_addr (bus.cpu_ab[MEM_AW-1:0]),
        .cpu_data (bus.cpu_do),
        .rd_data  (rd_data)
    );

    // Write cycles read as zero; anything outside the array reads open bus.
    always_comb begin
        cpu_di = OPEN_BUS;
        if (state == S_RUN) begin
            if (bus.cpu_we)      cpu_di = '0;
            else if (cpu_mapped) cpu_di = rd_data;
        end
    end

    assign bus.cpu_di      = cpu_di;
    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_overflow = overflow_q;

endmodule

// File: doc/c64_bus_memory.md
# c64_bus_memory

Memory responder at the far end of the `_6502` CPU bus, used in place of a behavioural RAM model. It serves CPU read and write cycles from an on-chip byte array and owns CPU start-up. After reset it accepts a program image over a byte-stream loader port while holding the CPU in reset, then releases the CPU to run from that image. It sits between the CPU core and the top-level boot source.

## Interface
Parameters:
- `MEM_AW`, 10: memory address width. Depth is 2^MEM_AW bytes, mapped at CPU addresses 0 .. 2^MEM_AW-1.
- `HOLD_CYC`, 4: number of cycles the CPU is kept in reset after the last loader byte.
- `OPEN_BUS`, 8'hFF: read value for unmapped addresses.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `cpu_ab` in 16: CPU address bus.
- `cpu_we` in 1: CPU write strobe, 1 = write cycle.
- `cpu_do` in 8: CPU write data.
- `cpu_di` out 8: read data to the CPU.
- `cpu_reset` out 1: active-high reset to the CPU core.
- `ld_valid` in 1: loader byte valid.
- `ld_data` in 8: loader byte.
- `ld_last` in 1: marks the final byte of the image; sampled with `ld_valid`.
- `ld_ready` out 1: block accepts a loader byte this cycle.
- `ld_overflow` out 1: sticky flag, set when the image exceeded the memory depth.

## Operation
- States are `S_INIT`, `S_LOAD`, `S_HOLD`, `S_RUN`. Asynchronous reset enters `S_INIT`.
- `S_INIT`: lasts one cycle, clears the load pointer and `ld_overflow`, then goes to `S_LOAD`.
- `S_LOAD`:
  - `ld_ready`=1.
  - A transfer occurs on `ld_valid && ld_ready` at a rising edge. The byte is written to `mem[ptr]` and `ptr` increments.
  - `ptr` is MEM_AW+1 bits wide. Once `ptr` reaches 2^MEM_AW, further bytes are accepted but dropped, and `ld_overflow` is set. `ptr` saturates and does not wrap.
  - A transfer with `ld_last`=1 moves the state to `S_HOLD`.
  - CPU writes are ignored in this state.
- `S_HOLD`: the hold counter is loaded with HOLD_CYC-1 and counts down. At 0 the state moves to `S_RUN`. `ld_ready`=0.
- `S_RUN`:
  - The CPU owns the memory.
  - When `cpu_we`=1 and `cpu_ab` < 2^MEM_AW, `mem[cpu_ab[MEM_AW-1:0]]` <= `cpu_do` at the edge.
  - Writes to unmapped addresses are dropped.
  - `ld_valid` is ignored, and `ld_ready`=0.
- `cpu_reset` = 1 in every state except `S_RUN`.
- `cpu_di` is combinational:
  - `cpu_we`=1 gives 8'h00.
  - An unmapped address gives `OPEN_BUS`.
  - Otherwise `cpu_di` = `mem[cpu_ab]`.
  - In states other than `S_RUN`, `cpu_di` = `OPEN_BUS`.
- Memory contents are not cleared by reset. Bytes not covered by the image keep prior contents and are undefined after power-up.

## Timing
- Reset values: `cpu_reset`=1, `ld_ready`=0, `ld_overflow`=0, state=`S_INIT`.
- `ld_ready` is registered. It rises 1 cycle after reset deasserts (the `S_INIT` cycle) and falls in the cycle after the `ld_last` transfer.
- The loader is throughput 1 byte/cycle with no bubbles.
- `cpu_reset` falls exactly HOLD_CYC cycles after the edge that accepts `ld_last`.
- Read latency is 0 cycles: `cpu_di` follows `cpu_ab` in the same cycle, as the CPU samples it.
- Read of the address being written in the same cycle returns 8'h00 (`cpu_we`=1). The next cycle's read returns the new data.
- `ld_last` on a dropped overflow byte still ends the load.
- Reset asserted mid-load or mid-run:
  - The next cycle is `S_INIT`.
  - `cpu_reset` goes to 1 immediately (asynchronously).
  - Partial image bytes remain in memory.
- An `ld_valid` transfer and `cpu_we` in the same cycle cannot conflict, because only one side is enabled per state.

## Structure
- Shared package `c64_bus_pkg`:
  - State encoding constants `S_INIT`/`S_LOAD`/`S_HOLD`/`S_RUN` (2 bits).
  - `OPEN_BUS` default.
  - CPU bus widths (16-bit address, 8-bit data).
- One sub-module: `c64_bus_ram`, a single-port byte array with combinational read and synchronous write. It owns the mem array and the write mux, selecting loader or CPU by state. The FSM, counters and decode stay in the top.

## Test plan
- Reset, load 5 bytes A9 27 8D 11 00 with `ld_last` on the 5th → `ld_ready` is high for 5 cycles; `cpu_reset` falls 4 cycles after the last byte; reads of addresses 0..4 return A9 27 8D 11 00.
- In `S_RUN`, CPU writes `cpu_ab`=0x0011, `cpu_do`=0x27 → `cpu_di` is 0x00 during the write cycle; the next read of 0x0011 returns 0x27.
- In `S_RUN`, read of 0x0400 with MEM_AW=10 → `cpu_di`=0xFF. A write of 0x55 to 0x0400 leaves `mem[0]` unchanged.
- Load 1025 bytes (value = index & 0xFF), `ld_last` on the last → `ld_overflow`=1; `mem[0]`=0x00 and `mem[1023]`=0xFF; the CPU is still released.
- Drive `ld_valid` with gaps (1 cycle on, 2 off) → exactly the valid bytes are stored, in order.
- Assert `reset` after 3 of 8 bytes, then reload 2 bytes 11 22 → `cpu_reset` stays 1 throughout; after release `mem[0..1]`=11 22 and `mem[2]` keeps the earlier byte.
